// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  localparam int unsigned PORT_DATA  = 0;
  localparam int unsigned PORT_FETCH = 1;
  localparam int unsigned PORT_DMA   = 2;

  // Index width that still works for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with modports.
interface mem_port_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner select: first asserted request at or after ptr, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NREQ       = 3,
  parameter  int unsigned FIXED_PRIO = 0,
  localparam int unsigned PW         = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            any
);

  int unsigned start;
  int unsigned idx;
  logic        found;

  // Fixed priority is round-robin pinned to index 0.
  always_comb begin
    start   = (FIXED_PRIO != 0) ? 32'd0 : 32'(ptr);
    idx     = 32'd0;
    found   = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found   = 1'b1;
        win_oh  = NREQ'(1) << idx;
        win_idx = PW'(idx);
      end
    end
    any = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by NREQ requesters; one transaction at a time,
// registered memory bus, read data returned RD_LAT cycles after the grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned PW = idx_w(NREQ);
  localparam int unsigned CW = idx_w(RD_LAT);
  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_RD_WAIT = RD_WAIT;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ), .FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (pick_any)
  );

  // Next state: grant in IDLE, count down read latency in RD_WAIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    mem_we_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d       = win_oh;
          mem_addr_d  = bus.addr[win_idx*AW +: AW];
          mem_wdata_d = bus.wdata[win_idx*DW +: DW];
          mem_we_d    = bus.we[win_idx];
          ptr_d       = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          if (!bus.we[win_idx]) begin
            state_d = ST_RD_WAIT;
            cnt_d   = CW'(RD_LAT - 1);
            busy_d  = 1'b1;
            owner_d = win_idx;
          end
        end
      end
      default: begin
        if (cnt_q == '0) begin
          rvalid_d = NREQ'(1) << owner_q;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.busy      = busy_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // Read data passes straight through from the memory.
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance driven from a vector table, plus
// fixed-priority and RD_LAT=3 instances exercised by hand-written sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] MEM_KEY = 32'hDEADBEAF;

  logic clk = 1'b0;
  logic rst_main = 1'b0;
  logic rst_l3 = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) b_rr ();
  mem_port_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) b_fp ();
  mem_port_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) b_l3 ();

  // Memory model: read data is the address scrambled by a fixed key.
  assign b_rr.mem_rdata = b_rr.mem_addr ^ MEM_KEY;
  assign b_fp.mem_rdata = b_fp.mem_addr ^ MEM_KEY;
  assign b_l3.mem_rdata = b_l3.mem_addr ^ MEM_KEY;

  mem_port_arbiter #(.NREQ(3), .AW(32), .DW(32), .RD_LAT(1), .FIXED_PRIO(0))
    dut_rr (.clk(clk), .rst(rst_main), .bus(b_rr));
  mem_port_arbiter #(.NREQ(3), .AW(32), .DW(32), .RD_LAT(1), .FIXED_PRIO(1))
    dut_fp (.clk(clk), .rst(rst_main), .bus(b_fp));
  mem_port_arbiter #(.NREQ(3), .AW(32), .DW(32), .RD_LAT(3), .FIXED_PRIO(0))
    dut_l3 (.clk(clk), .rst(rst_l3), .bus(b_l3));

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] a0, a1, a2, wd;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        busy;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vt[0:31];
  int unsigned nv = 0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned order[9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] we,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] wd,
                              input logic [2:0] gnt, input logic [2:0] rvalid,
                              input logic mwe, input logic [31:0] maddr,
                              input logic [31:0] mwd, input logic busy,
                              input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd;
    v.gnt = gnt; v.rvalid = rvalid; v.mwe = mwe; v.maddr = maddr;
    v.mwd = mwd; v.busy = busy; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input vec_t v);
    vt[nv] = v;
    nv++;
  endtask

  initial begin
    logic [31:0] a;
    b_rr.req = '0; b_rr.we = '0; b_rr.addr = '0; b_rr.wdata = '0;
    b_fp.req = '0; b_fp.we = '0; b_fp.addr = '0; b_fp.wdata = '0;
    b_l3.req = '0; b_l3.we = '0; b_l3.addr = '0; b_l3.wdata = '0;

    // Single read, back-to-back writes, idle hold.
    add(mk(3'b010, 3'b000, 0, 32'h40, 0, 0,            3'b010, 3'b000, 0, 32'h40, 0, 1, 0));
    add(mk(3'b000, 3'b000, 0, 32'h40, 0, 0,            3'b000, 3'b010, 0, 32'h40, 0, 0, 32'hDEADBEEF));
    add(mk(3'b001, 3'b001, 32'h10, 0, 0, 32'hA5A50010, 3'b001, 3'b000, 1, 32'h10, 32'hA5A50010, 0, 0));
    add(mk(3'b001, 3'b001, 32'h14, 0, 0, 32'hA5A50014, 3'b001, 3'b000, 1, 32'h14, 32'hA5A50014, 0, 0));
    add(mk(3'b000, 3'b000, 32'h14, 0, 0, 32'hA5A50014, 3'b000, 3'b000, 0, 32'h14, 32'hA5A50014, 0, 0));
    // All three reading continuously: pointer sits at 1 after the writes.
    for (int k = 0; k < 9; k++) begin
      a = (order[k] + 1) * 32'h100;
      add(mk(3'b111, 3'b000, 32'h100, 32'h200, 32'h300, 0,
             3'(1 << order[k]), 3'b000, 0, a, 0, 1, 0));
      add(mk(3'b111, 3'b000, 32'h100, 32'h200, 32'h300, 0,
             3'b000, 3'(1 << order[k]), 0, a, 0, 0, a ^ MEM_KEY));
    end
    // Read from 2; requester 1 shows up during RD_WAIT then withdraws.
    add(mk(3'b100, 3'b000, 32'h100, 32'h200, 32'h300, 0, 3'b100, 3'b000, 0, 32'h300, 0, 1, 0));
    add(mk(3'b010, 3'b000, 32'h100, 32'h200, 32'h300, 0, 3'b000, 3'b100, 0, 32'h300, 0, 0, 32'hDEADBDAF));
    add(mk(3'b001, 3'b000, 32'h100, 32'h200, 32'h300, 0, 3'b001, 3'b000, 0, 32'h100, 0, 1, 0));
    add(mk(3'b000, 3'b000, 32'h100, 32'h200, 32'h300, 0, 3'b000, 3'b001, 0, 32'h100, 0, 0, 32'hDEADBFAF));

    // Reset state.
    tick(); tick();
    chk("rst gnt", 32'(b_rr.gnt), 0);
    chk("rst rvalid", 32'(b_rr.rvalid), 0);
    chk("rst mem_we", 32'(b_rr.mem_we), 0);
    chk("rst mem_addr", b_rr.mem_addr, 0);
    chk("rst mem_wdata", b_rr.mem_wdata, 0);
    chk("rst busy", 32'(b_rr.busy), 0);
    rst_main = 1'b1;
    rst_l3   = 1'b1;
    tick();

    for (int unsigned i = 0; i < nv; i++) begin
      b_rr.req   = vt[i].req;
      b_rr.we    = vt[i].we;
      b_rr.addr  = {vt[i].a2, vt[i].a1, vt[i].a0};
      b_rr.wdata = {3{vt[i].wd}};
      tick();
      chk($sformatf("v%0d gnt", i), 32'(b_rr.gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d rvalid", i), 32'(b_rr.rvalid), 32'(vt[i].rvalid));
      chk($sformatf("v%0d mem_we", i), 32'(b_rr.mem_we), 32'(vt[i].mwe));
      chk($sformatf("v%0d mem_addr", i), b_rr.mem_addr, vt[i].maddr);
      chk($sformatf("v%0d mem_wdata", i), b_rr.mem_wdata, vt[i].mwd);
      chk($sformatf("v%0d busy", i), 32'(b_rr.busy), 32'(vt[i].busy));
      if (vt[i].rvalid != 3'b000)
        chk($sformatf("v%0d rdata", i), b_rr.rdata, vt[i].rdata);
    end

    // Fixed priority: index 0 wins every cycle while it keeps requesting.
    b_fp.req   = 3'b111;
    b_fp.we    = 3'b111;
    b_fp.addr  = {32'h28, 32'h24, 32'h20};
    b_fp.wdata = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fp%0d gnt", k), 32'(b_fp.gnt), 32'(1) << PORT_DATA);
      chk($sformatf("fp%0d mem_we", k), 32'(b_fp.mem_we), 1);
      chk($sformatf("fp%0d mem_addr", k), b_fp.mem_addr, 32'h20);
    end
    b_fp.req = 3'b110;
    tick();
    chk("fp drop0 gnt", 32'(b_fp.gnt), 32'(1) << PORT_FETCH);
    chk("fp drop0 mem_wdata", b_fp.mem_wdata, 32'hC0DE0001);
    b_fp.req = 3'b100;
    tick();
    chk("fp dma gnt", 32'(b_fp.gnt), 32'(1) << PORT_DMA);
    chk("fp dma mem_addr", b_fp.mem_addr, 32'h28);
    b_fp.req = 3'b000;
    tick();
    chk("fp idle gnt", 32'(b_fp.gnt), 0);
    chk("fp idle mem_we", 32'(b_fp.mem_we), 0);

    // RD_LAT=3: reset one cycle after the grant kills the pending rvalid.
    b_l3.req   = 3'b001;
    b_l3.we    = 3'b000;
    b_l3.addr  = {32'h0, 32'h0, 32'h80};
    b_l3.wdata = {3{32'h12345678}};
    tick();
    chk("l3 gnt", 32'(b_l3.gnt), 32'b001);
    chk("l3 busy", 32'(b_l3.busy), 1);
    chk("l3 mem_wdata", b_l3.mem_wdata, 32'h12345678);
    b_l3.req = 3'b000;
    tick();
    chk("l3 wait rvalid", 32'(b_l3.rvalid), 0);
    rst_l3 = 1'b0;
    #1;
    chk("l3 rst gnt", 32'(b_l3.gnt), 0);
    chk("l3 rst busy", 32'(b_l3.busy), 0);
    chk("l3 rst mem_addr", b_l3.mem_addr, 0);
    chk("l3 rst mem_wdata", b_l3.mem_wdata, 0);
    chk("l3 rst mem_we", 32'(b_l3.mem_we), 0);
    tick();
    rst_l3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("l3 post-rst%0d rvalid", k), 32'(b_l3.rvalid), 0);
    end
    b_l3.req  = 3'b001;
    b_l3.addr = {32'h0, 32'h0, 32'h84};
    tick();
    chk("l3 re gnt", 32'(b_l3.gnt), 32'b001);
    chk("l3 re mem_addr", b_l3.mem_addr, 32'h84);
    b_l3.req = 3'b000;
    for (int k = 1; k < 3; k++) begin
      tick();
      chk($sformatf("l3 re C+%0d rvalid", k), 32'(b_l3.rvalid), 0);
      chk($sformatf("l3 re C+%0d busy", k), 32'(b_l3.busy), 1);
    end
    tick();
    chk("l3 re rvalid", 32'(b_l3.rvalid), 32'b001);
    chk("l3 re rdata", b_l3.rdata, 32'hDEADBE2B);
    chk("l3 re busy", 32'(b_l3.busy), 0);
    tick();
    chk("l3 re rvalid pulse", 32'(b_l3.rvalid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
